dll_phase_sel_ctrl: RTL and testbench
=====================================

// Module: dll_phase_sel_ctrl
// PURPOSE
//   Phase-select controller for the FMDLL coarse delay line. Drives the 3-bit
//   select Q and the 4-bit step count into the 3-to-8 phase decoder (T/Tb).
//   Runs a 3-step SAR search over 8 phases from phase-detector decisions, then
//   bounded +/-1 tracking until lock. On timeout it parks count at 15, which
//   makes the decoder fall back to midpoint phase T=8'b00010000.
// PARAMETERS
//   SETTLE_CYC   4  cycles to wait after any Q change before sampling PD (>=1)
//   COUNT_LIMIT  5  max PD decisions before timeout; must be 3..14 (matches decoder count<=5 gate)
// PORTS
//   clk       in   1  clock, all logic on rising edge
//   rst       in   1  synchronous reset, active-high
//   start     in   1  1-cycle pulse: begin/restart search (honoured in IDLE, DONE, FAIL)
//   pd_valid  in   1  PD decision strobe (1 cycle)
//   pd_up     in   1  PD: delay too short, increase Q
//   pd_dn     in   1  PD: delay too long, decrease Q
//   Q         out  3  phase select to decoder (registered)
//   count     out  4  decisions taken; 4'hF = failed/park (registered)
//   busy      out  1  high in SETTLE/SAMPLE
//   locked    out  1  high in DONE
//   fail      out  1  high in FAIL
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, Q=3'd4, count=0, busy=locked=fail=0, settle cnt=0.
//   States: IDLE, SETTLE, SAMPLE, DONE, FAIL. All outputs registered.
//   IDLE/DONE/FAIL + start: next cycle Q=3'b100, count=0, locked=fail=0, -> SETTLE.
//   start in SETTLE/SAMPLE ignored.
//   SETTLE: count SETTLE_CYC cycles, then -> SAMPLE. pd_valid ignored here.
//   SAMPLE: wait for pd_valid; each accepted decision: count<=count+1, update Q next cycle.
//     up = pd_up & ~pd_dn; dn = pd_dn & ~pd_up; neutral = (pd_up == pd_dn).
//   SAR phase (count 0..2 at decision; bit b = 2-count):
//     keep bit b if up, else clear it; if b>0 set bit b-1. -> SETTLE.
//     neutral counts as not-up during SAR.
//   Tracking (count>=3 at decision):
//     neutral -> DONE, Q held, count incremented.
//     up/dn -> if count+1 > COUNT_LIMIT: -> FAIL, Q=3'd4, count=4'hF.
//       Otherwise Q+1 (up) or Q-1 (dn) -> SETTLE.
//       Saturate: Q=7 with up and Q=0 with dn hold Q, still count, then -> SETTLE.
//   DONE: Q/count frozen, locked=1; pd_valid ignored.
//   FAIL: Q=4, count=15, fail=1; pd_valid ignored.
//   Latency: start at edge n -> busy=1 after edge n; first sample window opens
//     SETTLE_CYC cycles later. Q change visible 1 cycle after the pd_valid edge.
//   rst mid-operation overrides all and gives reset values on the next edge.
//   count never wraps: max in-search value is COUNT_LIMIT, then 15 on fail.
// TESTING
//   1 rst=1 two cycles, random inputs -> Q=4, count=0, busy=locked=fail=0.
//   2 start; decisions up,dn,up,neutral -> Q seq 4,6,5,5;
//     count 0,1,2,3,4; locked=1, Q=5.
//   3 start; dn,dn,dn,dn,dn,dn -> Q 4,2,1,0,0,0;
//     6th decision -> fail=1, Q=4, count=15.
//   4 pd_valid pulses during SETTLE and DONE -> count and Q unchanged.
//   5 rst asserted in SAMPLE after 2 decisions -> next cycle IDLE reset values;
//     start in SETTLE -> no restart.
//   6 from DONE (Q=5) pulse start -> Q=4, count=0, locked=0, busy=1;
//     SAMPLE entered exactly SETTLE_CYC cycles later.

Source files
------------

// File: rtl/dll_phase_sel_ctrl.sv
// Phase-select controller for the FMDLL coarse delay line: 3-step SAR search over 8 phases,
// then bounded +/-1 tracking until the phase detector reports neutral (lock) or a timeout.
module dll_phase_sel_ctrl #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned COUNT_LIMIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pd_valid,
    input  logic       pd_up,
    input  logic       pd_dn,
    output logic [2:0] Q,
    output logic [3:0] count,
    output logic       busy,
    output logic       locked,
    output logic       fail
);

    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYC - 1);
    localparam logic [4:0] CountLimit = 5'(COUNT_LIMIT);
    localparam logic [2:0] QMid = 3'd4;
    localparam logic [3:0] CountPark = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StDone,
        StFail
    } state_e;

    state_e state_q, state_d;
    logic [2:0] q_q, q_d;
    logic [3:0] count_q, count_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic busy_q, busy_d;
    logic locked_q, locked_d;
    logic fail_q, fail_d;

    logic up, dn;
    logic [4:0] count_inc;
    logic [2:0] sar_q;
    logic [2:0] track_q;

    assign up = pd_up & ~pd_dn;
    assign dn = pd_dn & ~pd_up;
    assign count_inc = {1'b0, count_q} + 5'd1;

    // SAR step on bit b = 2 - count: keep b only on up, then arm bit b-1.
    always_comb begin
        sar_q = q_q;
        unique case (count_q[1:0])
            2'd0:    sar_q = {q_q[2] & up, 1'b1, q_q[0]};
            2'd1:    sar_q = {q_q[2], q_q[1] & up, 1'b1};
            default: sar_q = {q_q[2:1], q_q[0] & up};
        endcase
    end

    // Tracking step saturates at the ends of the phase range.
    always_comb begin
        track_q = q_q;
        if (up && q_q != 3'd7) begin
            track_q = q_q + 3'd1;
        end else if (dn && q_q != 3'd0) begin
            track_q = q_q - 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        count_d  = count_q;
        settle_d = settle_q;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (start) begin
                    state_d  = StSettle;
                    q_d      = QMid;
                    count_d  = 4'd0;
                    settle_d = '0;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d  = StSample;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StSample: begin
                if (pd_valid) begin
                    if (count_q < 4'd3) begin
                        state_d  = StSettle;
                        settle_d = '0;
                        q_d      = sar_q;
                        count_d  = count_inc[3:0];
                    end else if (!up && !dn) begin
                        state_d = StDone;
                        count_d = count_inc[3:0];
                    end else if (count_inc > CountLimit) begin
                        state_d = StFail;
                        q_d     = QMid;
                        count_d = CountPark;
                    end else begin
                        state_d  = StSettle;
                        settle_d = '0;
                        q_d      = track_q;
                        count_d  = count_inc[3:0];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d   = (state_d == StSettle) || (state_d == StSample);
        locked_d = (state_d == StDone);
        fail_d   = (state_d == StFail);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            q_q      <= QMid;
            count_q  <= 4'd0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            count_q  <= count_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    assign Q      = q_q;
    assign count  = count_q;
    assign busy   = busy_q;
    assign locked = locked_q;
    assign fail   = fail_q;

endmodule

// File: tb/tb_dll_phase_sel_ctrl.sv
// Directed bench for dll_phase_sel_ctrl: inputs driven and outputs sampled on the falling edge,
// each check is an immediate assertion against hand-computed values.
module tb_dll_phase_sel_ctrl;

    localparam int unsigned SettleCyc = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pd_valid;
    logic       pd_up;
    logic       pd_dn;
    logic [2:0] Q;
    logic [3:0] count;
    logic       busy;
    logic       locked;
    logic       fail;

    int checks = 0;
    int failures = 0;

    dll_phase_sel_ctrl #(
        .SETTLE_CYC (SettleCyc),
        .COUNT_LIMIT(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pd_valid(pd_valid),
        .pd_up   (pd_up),
        .pd_dn   (pd_dn),
        .Q       (Q),
        .count   (count),
        .busy    (busy),
        .locked  (locked),
        .fail    (fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_q, input logic [3:0] exp_c,
                       input logic exp_b, input logic exp_l, input logic exp_f);
        checks++;
        assert ({Q, count, busy, locked, fail} === {exp_q, exp_c, exp_b, exp_l, exp_f})
        else begin
            failures++;
            $error("FAIL %s: observed Q=%0d count=%0d busy=%b locked=%b fail=%b, expected Q=%0d count=%0d busy=%b locked=%b fail=%b",
                   tag, Q, count, busy, locked, fail, exp_q, exp_c, exp_b, exp_l, exp_f);
        end
    endtask

    task automatic settle();
        pd_valid = 1'b0;
        repeat (SettleCyc) tick();
    endtask

    task automatic decide(input logic u, input logic d);
        pd_valid = 1'b1;
        pd_up    = u;
        pd_dn    = d;
        tick();
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        pd_dn    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        pd_dn    = 1'b0;

        // Reset with random inputs.
        repeat (2) begin
            start    = 1'($urandom_range(0, 1));
            pd_valid = 1'($urandom_range(0, 1));
            pd_up    = 1'($urandom_range(0, 1));
            pd_dn    = 1'($urandom_range(0, 1));
            tick();
        end
        chk("reset", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        start    = 1'b0;
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        pd_dn    = 1'b0;
        tick();
        chk("idle_hold", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);

        // Search up, dn, up, neutral -> lock at Q=5.
        pulse_start();
        chk("start1", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("sar0_up", 3'd6, 4'd1, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("sar1_dn", 3'd5, 4'd2, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("sar2_up", 3'd5, 4'd3, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b1);
        chk("lock", 3'd5, 4'd4, 1'b0, 1'b1, 1'b0);

        // pd_valid in DONE is ignored.
        decide(1'b0, 1'b1);
        chk("done_pd_ignored", 3'd5, 4'd4, 1'b0, 1'b1, 1'b0);

        // Restart from DONE; SAMPLE opens exactly SettleCyc cycles after start.
        pulse_start();
        chk("restart_done", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (SettleCyc - 1) tick();
        pd_valid = 1'b1;
        pd_up    = 1'b1;
        tick();
        chk("settle_pd_ignored", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        chk("first_sample_edge", 3'd6, 4'd1, 1'b1, 1'b0, 1'b0);

        // Reset in SAMPLE after two decisions.
        settle();
        decide(1'b0, 1'b1);
        chk("pre_rst_dec", 3'd5, 4'd2, 1'b1, 1'b0, 1'b0);
        settle();
        rst      = 1'b1;
        pd_valid = 1'b1;
        pd_up    = 1'b1;
        tick();
        rst      = 1'b0;
        pd_valid = 1'b0;
        pd_up    = 1'b0;
        chk("rst_mid_sample", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start during SETTLE must not restart the settle window.
        pulse_start();
        tick();
        pulse_start();
        chk("start_in_settle", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (SettleCyc - 2) tick();
        decide(1'b0, 1'b1);
        chk("dn_sar0", 3'd2, 4'd1, 1'b1, 1'b0, 1'b0);

        // All-down run into timeout.
        settle();
        decide(1'b0, 1'b1);
        chk("dn_sar1", 3'd1, 4'd2, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("dn_sar2", 3'd0, 4'd3, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("dn_sat4", 3'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("dn_sat5", 3'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("timeout", 3'd4, 4'd15, 1'b0, 1'b0, 1'b1);
        decide(1'b1, 1'b0);
        chk("fail_pd_ignored", 3'd4, 4'd15, 1'b0, 1'b0, 1'b1);

        // Restart from FAIL; all-up run saturates at 7, then one tracking step down.
        pulse_start();
        chk("restart_fail", 3'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("up_sar0", 3'd6, 4'd1, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("up_sar1", 3'd7, 4'd2, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("up_sar2", 3'd7, 4'd3, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b1, 1'b0);
        chk("up_sat", 3'd7, 4'd4, 1'b1, 1'b0, 1'b0);
        settle();
        decide(1'b0, 1'b1);
        chk("track_dn", 3'd6, 4'd5, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
